// File: rtl/uart_cmd_parser.sv
// ASCII command parser for a stopwatch: S/P/C commands and "Tmmss<CR>" time load.
// Define CMD_ECHO_EN to echo every received byte through a one-entry register to the transmitter.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic       cmd_clear,
    output logic       cmd_load,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic       err,
    output logic       busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DIGIT, TERM} state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         minTens_q, minTens_d, minUnits_q, minUnits_d;
    logic [3:0]         secTens_q, secTens_d, secUnits_q, secUnits_d;
    logic [5:0]         loadMin_q, loadMin_d, loadSec_q, loadSec_d;
    logic               cmdStart_q, cmdStart_d, cmdStop_q, cmdStop_d;
    logic               cmdClear_q, cmdClear_d, cmdLoad_q, cmdLoad_d;
    logic               err_q, err_d;
    logic               isDigit, timeout;

    function automatic logic [5:0] toBin(input logic [3:0] tens, input logic [3:0] units);
        return 6'(tens) * 6'd10 + 6'(units);
    endfunction

    assign isDigit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        minTens_d  = minTens_q;
        minUnits_d = minUnits_q;
        secTens_d  = secTens_q;
        secUnits_d = secUnits_q;
        loadMin_d  = loadMin_q;
        loadSec_d  = loadSec_q;
        cmdStart_d = 1'b0;
        cmdStop_d  = 1'b0;
        cmdClear_d = 1'b0;
        cmdLoad_d  = 1'b0;
        err_d      = 1'b0;

        if (rx_done_tick) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    case (rx_data)
                        8'h53, 8'h73: cmdStart_d = 1'b1;
                        8'h50, 8'h70: cmdStop_d  = 1'b1;
                        8'h43, 8'h63: cmdClear_d = 1'b1;
                        8'h54, 8'h74: begin
                            state_d = DIGIT;
                            idx_d   = 2'd0;
                        end
                        8'h0D, 8'h0A: ;
                        default:      err_d = 1'b1;
                    endcase
                end
                DIGIT: begin
                    // Tens positions (idx 0 and 2) are limited to 0..5.
                    if (!isDigit || (!idx_q[0] && (rx_data[3:0] > 4'd5))) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        idx_d   = 2'd0;
                    end else begin
                        case (idx_q)
                            2'd0: minTens_d  = rx_data[3:0];
                            2'd1: minUnits_d = rx_data[3:0];
                            2'd2: secTens_d  = rx_data[3:0];
                            default: begin
                                secUnits_d = rx_data[3:0];
                                state_d    = TERM;
                            end
                        endcase
                        idx_d = idx_q + 2'd1;
                    end
                end
                TERM: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    if (rx_data == 8'h0D) begin
                        cmdLoad_d = 1'b1;
                        loadMin_d = toBin(minTens_q, minUnits_q);
                        loadSec_d = toBin(secTens_q, secUnits_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end
            endcase
        end else if (state_q != IDLE) begin
            // A byte in the expiry cycle takes the branch above, so it always wins.
            if (timeout) begin
                err_d   = 1'b1;
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if ((state_d == IDLE) && (state_q != IDLE)) begin
            minTens_d  = (cmdLoad_d) ? minTens_d : 4'd0;
            minUnits_d = (cmdLoad_d) ? minUnits_d : 4'd0;
            secTens_d  = (cmdLoad_d) ? secTens_d : 4'd0;
            secUnits_d = (cmdLoad_d) ? secUnits_d : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            minTens_q  <= 4'd0;
            minUnits_q <= 4'd0;
            secTens_q  <= 4'd0;
            secUnits_q <= 4'd0;
            loadMin_q  <= 6'd0;
            loadSec_q  <= 6'd0;
            cmdStart_q <= 1'b0;
            cmdStop_q  <= 1'b0;
            cmdClear_q <= 1'b0;
            cmdLoad_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            minTens_q  <= minTens_d;
            minUnits_q <= minUnits_d;
            secTens_q  <= secTens_d;
            secUnits_q <= secUnits_d;
            loadMin_q  <= loadMin_d;
            loadSec_q  <= loadSec_d;
            cmdStart_q <= cmdStart_d;
            cmdStop_q  <= cmdStop_d;
            cmdClear_q <= cmdClear_d;
            cmdLoad_q  <= cmdLoad_d;
            err_q      <= err_d;
        end
    end

    assign cmd_start = cmdStart_q;
    assign cmd_stop  = cmdStop_q;
    assign cmd_clear = cmdClear_q;
    assign cmd_load  = cmdLoad_q;
    assign err       = err_q;
    assign load_min  = loadMin_q;
    assign load_sec  = loadSec_q;
    assign busy      = (state_q != IDLE);

`ifdef CMD_ECHO_EN
    logic [7:0] echo_q, echo_d;
    logic       pending_q, pending_d;

    // A new byte overrides the clear of a byte handed off in the same cycle.
    always_comb begin
        echo_d    = echo_q;
        pending_d = pending_q;
        if (pending_q && !tx_busy) begin
            pending_d = 1'b0;
        end
        if (rx_done_tick) begin
            echo_d    = rx_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_q    <= 8'd0;
            pending_q <= 1'b0;
        end else begin
            echo_q    <= echo_d;
            pending_q <= pending_d;
        end
    end

    assign tx_start = pending_q && !tx_busy;
    assign tx_data  = echo_q;
`else
    logic unusedTxBusy;
    assign unusedTxBusy = tx_busy;
    assign tx_start     = 1'b0;
    assign tx_data      = 8'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected pulses, a negedge monitor checks them.
module tb_uart_cmd_parser;

    typedef enum int {K_NONE, K_START, K_STOP, K_CLEAR, K_LOAD, K_ERR} kind_e;
    typedef struct {
        kind_e kind;
        int    cyc;
        int    min;
        int    sec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       cmd_start, cmd_stop, cmd_clear, cmd_load, err, busy, tx_start;
    logic [5:0] load_min, load_sec;
    logic [7:0] tx_data;

    exp_t sbQ[$];
    int   posCnt = 0;
    int   lastDrive = 0;
    int   assertCount = 0;
    int   failCount = 0;
    int   txCount = 0;
    int   txLastData = 0;
    int   nHigh;
    kind_e obsKind;
    exp_t  e;

    uart_cmd_parser #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .cmd_load(cmd_load),
        .load_min(load_min), .load_sec(load_sec), .err(err), .busy(busy),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) posCnt++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, posCnt);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input kind_e kind, input int min, input int sec);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        lastDrive    = posCnt;
        if (kind != K_NONE) sbQ.push_back('{kind, posCnt + 1, min, sec});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_done_tick = 1'b0;
        end
    endtask

    // Every visible pulse must match the head of the queue in kind, cycle and load values.
    always @(negedge clk) begin
        nHigh = int'(cmd_start) + int'(cmd_stop) + int'(cmd_clear) + int'(cmd_load) + int'(err);
        obsKind = err ? K_ERR : cmd_load ? K_LOAD : cmd_clear ? K_CLEAR : cmd_stop ? K_STOP :
                  cmd_start ? K_START : K_NONE;
        if (tx_start) begin
            txCount++;
            txLastData = int'(tx_data);
        end
        if (nHigh > 1) checkOutput("onehot_pulses", nHigh, 1);
        if (nHigh != 0) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_pulse", int'(obsKind), int'(K_NONE));
            end else begin
                e = sbQ.pop_front();
                checkOutput("pulse_kind", int'(obsKind), int'(e.kind));
                checkOutput("pulse_cycle", posCnt, e.cyc);
                if (e.kind == K_LOAD) begin
                    checkOutput("load_min", int'(load_min), e.min);
                    checkOutput("load_sec", int'(load_sec), e.sec);
                end
            end
        end else if (sbQ.size() != 0 && sbQ[0].cyc <= posCnt) begin
            e = sbQ.pop_front();
            checkOutput("missed_pulse", int'(K_NONE), int'(e.kind));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_load_min", int'(load_min), 0);
        checkOutput("rst_load_sec", int'(load_sec), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_tx_start", int'(tx_start), 0);
        checkOutput("rst_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        idleCycles(2);

        // Single-byte commands, partly back-to-back
        applyStimulus(8'h53, K_START, 0, 0);
        applyStimulus(8'h70, K_STOP, 0, 0);
        applyStimulus(8'h43, K_CLEAR, 0, 0);
        idleCycles(2);
        applyStimulus(8'h73, K_START, 0, 0);
        applyStimulus(8'h50, K_STOP, 0, 0);
        applyStimulus(8'h63, K_CLEAR, 0, 0);
        applyStimulus(8'h0D, K_NONE, 0, 0);
        applyStimulus(8'h0A, K_NONE, 0, 0);
        applyStimulus(8'h58, K_ERR, 0, 0);
        idleCycles(3);

        // Load 12:45 with busy observation
        applyStimulus("T", K_NONE, 0, 0);
        idleCycles(1);
        checkOutput("busy_after_T", int'(busy), 1);
        applyStimulus("1", K_NONE, 0, 0);
        applyStimulus("2", K_NONE, 0, 0);
        applyStimulus("4", K_NONE, 0, 0);
        applyStimulus("5", K_NONE, 0, 0);
        idleCycles(1);
        checkOutput("busy_in_term", int'(busy), 1);
        applyStimulus(8'h0D, K_LOAD, 12, 45);
        idleCycles(1);
        checkOutput("busy_after_load", int'(busy), 0);
        idleCycles(2);

        // Rejections: second tens 7, minute tens 6, non-digit, wrong terminator
        applyStimulus("T", K_NONE, 0, 0);
        applyStimulus("1", K_NONE, 0, 0);
        applyStimulus("2", K_NONE, 0, 0);
        applyStimulus("7", K_ERR, 0, 0);
        idleCycles(2);
        checkOutput("hold_load_min", int'(load_min), 12);
        checkOutput("hold_load_sec", int'(load_sec), 45);
        checkOutput("busy_after_err", int'(busy), 0);
        applyStimulus("5", K_ERR, 0, 0);
        applyStimulus("t", K_NONE, 0, 0);
        applyStimulus("6", K_ERR, 0, 0);
        applyStimulus("T", K_NONE, 0, 0);
        applyStimulus("1", K_NONE, 0, 0);
        applyStimulus("A", K_ERR, 0, 0);
        applyStimulus("T", K_NONE, 0, 0);
        applyStimulus("1", K_NONE, 0, 0);
        applyStimulus("2", K_NONE, 0, 0);
        applyStimulus("4", K_NONE, 0, 0);
        applyStimulus("5", K_NONE, 0, 0);
        applyStimulus("X", K_ERR, 0, 0);
        idleCycles(2);

        // Upper boundary 59:59, back-to-back
        applyStimulus("T", K_NONE, 0, 0);
        applyStimulus("5", K_NONE, 0, 0);
        applyStimulus("9", K_NONE, 0, 0);
        applyStimulus("5", K_NONE, 0, 0);
        applyStimulus("9", K_NONE, 0, 0);
        applyStimulus(8'h0D, K_LOAD, 59, 59);
        idleCycles(2);

        // Timeout: err 16 cycles after the 'T' edge
        applyStimulus("T", K_NONE, 0, 0);
        sbQ.push_back('{K_ERR, lastDrive + 17, 0, 0});
        idleCycles(20);
        checkOutput("busy_after_timeout", int'(busy), 0);

        // Byte arriving in the expiry cycle is processed, no timeout err
        applyStimulus("T", K_NONE, 0, 0);
        idleCycles(15);
        applyStimulus("1", K_NONE, 0, 0);
        applyStimulus("2", K_NONE, 0, 0);
        applyStimulus("4", K_NONE, 0, 0);
        applyStimulus("5", K_NONE, 0, 0);
        applyStimulus(8'h0D, K_LOAD, 12, 45);
        idleCycles(2);

        // Reset mid-command, coincident with a byte that would otherwise start
        applyStimulus("T", K_NONE, 0, 0);
        applyStimulus("1", K_NONE, 0, 0);
        applyStimulus("2", K_NONE, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        rx_done_tick = 1'b1;
        rx_data = 8'h53;
        @(negedge clk);
        rst = 1'b0;
        rx_done_tick = 1'b0;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_load_min", int'(load_min), 0);
        checkOutput("reset_load_sec", int'(load_sec), 0);
        idleCycles(2);
        applyStimulus("T", K_NONE, 0, 0);
        applyStimulus("0", K_NONE, 0, 0);
        applyStimulus("0", K_NONE, 0, 0);
        applyStimulus("0", K_NONE, 0, 0);
        applyStimulus("0", K_NONE, 0, 0);
        applyStimulus(8'h0D, K_LOAD, 0, 0);
        idleCycles(3);

`ifdef CMD_ECHO_EN
        txCount = 0;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        applyStimulus(8'h41, K_ERR, 0, 0);
        applyStimulus(8'h42, K_ERR, 0, 0);
        idleCycles(5);
        checkOutput("echo_held_while_busy", txCount, 0);
        @(posedge clk);
        #1 tx_busy = 1'b0;
        idleCycles(5);
        checkOutput("echo_count", txCount, 1);
        checkOutput("echo_data", txLastData, 8'h42);
`else
        @(posedge clk);
        #1 tx_busy = 1'b1;
        applyStimulus(8'h41, K_ERR, 0, 0);
        idleCycles(3);
        @(posedge clk);
        #1 tx_busy = 1'b0;
        idleCycles(3);
        checkOutput("tx_start_never", txCount, 0);
        checkOutput("tx_data_zero", int'(tx_data), 0);
`endif

        idleCycles(5);
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
